// File: rtl/flag_pkg.sv
// Shared flag/condition definitions: NZCV bit positions, condition-code
// encodings and the result-buffer state type.
package flag_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether an instruction with
// the given condition executes under the supplied NZCV flags.
module cond_eval
    import flag_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] NZCV,
    output logic       pass
);

    logic n, z, c, v;

    assign n = NZCV[FLAG_N];
    assign z = NZCV[FLAG_Z];
    assign c = NZCV[FLAG_C];
    assign v = NZCV[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural NZCV register plus a 2-entry in-order buffer of evaluated
// condition results, with a saturating count of skipped instructions.
//
//   state    | meaning
//   ---------+--------------------------------------------
//   ST_EMPTY | no result buffered, ready for a request
//   ST_ONE   | one result at head, ready for a request
//   ST_FULL  | two results buffered, requests back-pressured
module flag_cond_unit
    import flag_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [3:0]       Flag_In,
    input  logic             S,
    input  logic             Flag_Valid,
    output logic [3:0]       Flag,
    input  logic [3:0]       Cond,
    input  logic             Cond_Valid,
    output logic             Cond_Ready,
    output logic             Exec,
    output logic             Exec_Valid,
    input  logic             Exec_Ready,
    output logic [CNT_W-1:0] Skip_Cnt
);

    buf_state_e       state_q, state_d;
    logic [3:0]       flag_q;
    logic             head_q, tail_q;
    logic [CNT_W-1:0] skip_q;
    logic             flag_load;
    logic [3:0]       eval_flags;
    logic             eval_pass;
    logic             push, pop;

    // A flag update in the same cycle as a request is forwarded to the evaluator.
    assign flag_load  = Flag_Valid && S;
    assign eval_flags = flag_load ? Flag_In : flag_q;

    cond_eval u_cond_eval (
        .Cond (Cond),
        .NZCV (eval_flags),
        .pass (eval_pass)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        Cond_Ready = 1'b0;
        Exec_Valid = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                Cond_Ready = 1'b1;
                push       = Cond_Valid;
                if (push) state_d = ST_ONE;
            end
            ST_ONE: begin
                Cond_Ready = 1'b1;
                Exec_Valid = 1'b1;
                push       = Cond_Valid;
                pop        = Exec_Ready;
                if (push && !pop) begin
                    state_d = ST_FULL;
                end else if (!push && pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                Exec_Valid = 1'b1;
                pop        = Exec_Ready;
                if (pop) state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            flag_q <= 4'b0000;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            skip_q <= '0;
        end else begin
            if (flag_load) begin
                flag_q <= Flag_In;
            end
            // Push into ONE with a simultaneous pop replaces the head directly.
            if (push) begin
                if (state_q == ST_EMPTY || pop) begin
                    head_q <= eval_pass;
                end else begin
                    tail_q <= eval_pass;
                end
            end else if (pop && state_q == ST_FULL) begin
                head_q <= tail_q;
            end
            if (pop && !head_q && (skip_q != {CNT_W{1'b1}})) begin
                skip_q <= skip_q + 1'b1;
            end
        end
    end

    assign Flag     = flag_q;
    assign Exec     = Exec_Valid && head_q;
    assign Skip_Cnt = skip_q;

endmodule
